// File: rtl/multiple_of_3_pkg.sv
// Shared types and constants for the bit-serial divisibility detector.
package multiple_of_3_pkg;

    localparam int DEFAULT_MOD = 3;
    localparam int DEFAULT_SW  = $clog2(DEFAULT_MOD);

    // Residue as stored by the default build.
    typedef logic [DEFAULT_SW-1:0] residue_t;

    // Named residues for the divide-by-3 build, used by debug views and assertions.
    typedef enum logic [DEFAULT_SW-1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } state_t;

endpackage

// File: rtl/multiple_of_3_mod_step.sv
// One residue update step: (2*r + in) mod MOD without a divider.
// Because r < MOD and in <= 1, t = 2*r + in is always below 2*MOD,
// so one conditional subtract is enough.
module multiple_of_3_mod_step
    import multiple_of_3_pkg::*;
#(
    parameter int MOD = DEFAULT_MOD,
    localparam int SW = $clog2(MOD)
) (
    input  logic [SW-1:0] r,
    input  logic          in,
    output logic [SW-1:0] r_next
);

    localparam logic [SW:0] MOD_V = (SW+1)'(MOD);

    logic [SW:0] t;

    // Shift in the new bit, then fold back into range with a single subtract.
    always_comb begin
        t      = {r, in};
        r_next = t[SW-1:0];
        if (t >= MOD_V) begin
            r_next = SW'(t - MOD_V);
        end
    end

endmodule

// File: rtl/multiple_of_3.sv
// Bit-serial divisibility detector: MSB-first stream, out=1 while the
// value received so far is a multiple of MOD. Only the residue is kept,
// so streams of any length are handled.
module multiple_of_3
    import multiple_of_3_pkg::*;
#(
    parameter int MOD = DEFAULT_MOD
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    localparam int          SW    = $clog2(MOD);
    localparam logic [SW:0] MOD_V = (SW+1)'(MOD);

    if (MOD < 2 || MOD > 255) begin : g_bad_mod
        $error("multiple_of_3: MOD=%0d outside legal range 2..255", MOD);
    end

    logic [SW-1:0] r;
    logic [SW-1:0] step_next;
    logic [SW-1:0] r_next;
    logic          legal;

    multiple_of_3_mod_step #(
        .MOD(MOD)
    ) u_step (
        .r     (r),
        .in    (in),
        .r_next(step_next)
    );

    // An out-of-range residue can only come from an upset; drop straight back to zero.
    always_comb begin
        legal  = ({1'b0, r} < MOD_V);
        r_next = '0;
        if (legal) begin
            r_next = step_next;
        end
    end

    // Residue register; reset clears it immediately so the empty value reads as a multiple.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r <= '0;
        end else begin
            r <= r_next;
        end
    end

    // Moore output straight from the register, no path from in.
    assign out = (r == '0);

    a_out_decode : assert property (@(posedge clk) disable iff (!reset)
        out == (r == '0));

    a_step : assert property (@(posedge clk) disable iff (!reset)
        legal |-> (int'(r_next) == ((2 * int'(r) + int'(in)) % MOD)));

    a_recover : assert property (@(posedge clk) disable iff (!reset)
        !legal |-> (r_next == '0));

    if (MOD == 3) begin : g_mod3
        state_t cur_state;
        state_t nxt_state;

        assign cur_state = state_t'(residue_t'(r));
        assign nxt_state = state_t'(residue_t'(r_next));

        a_s0_0 : assert property (@(posedge clk) disable iff (!reset)
            (cur_state == S0 && !in) |-> nxt_state == S0);
        a_s0_1 : assert property (@(posedge clk) disable iff (!reset)
            (cur_state == S0 && in)  |-> nxt_state == S1);
        a_s1_0 : assert property (@(posedge clk) disable iff (!reset)
            (cur_state == S1 && !in) |-> nxt_state == S2);
        a_s1_1 : assert property (@(posedge clk) disable iff (!reset)
            (cur_state == S1 && in)  |-> nxt_state == S0);
        a_s2_0 : assert property (@(posedge clk) disable iff (!reset)
            (cur_state == S2 && !in) |-> nxt_state == S1);
        a_s2_1 : assert property (@(posedge clk) disable iff (!reset)
            (cur_state == S2 && in)  |-> nxt_state == S2);
    end

endmodule

// File: tb/tb_multiple_of_3.sv
// Bench for multiple_of_3: a MOD=3 and a MOD=5 instance, checked against
// a big-integer model of the accumulated value through an output queue.
module tb_multiple_of_3;

    logic clk;
    logic rst3;
    logic rst5;
    logic in3;
    logic in5;
    logic out3;
    logic out5;

    int checks;
    int errors;

    logic [127:0] val3;
    logic [127:0] val5;
    logic         exp3_q[$];
    logic         exp5_q[$];
    logic         e3;
    logic         e5;

    multiple_of_3 #(.MOD(3)) dut3 (
        .clk  (clk),
        .reset(rst3),
        .in   (in3),
        .out  (out3)
    );

    multiple_of_3 #(.MOD(5)) dut5 (
        .clk  (clk),
        .reset(rst5),
        .in   (in5),
        .out  (out5)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one bit to each DUT now and queue the expected out after the next edge.
    task automatic drive(input logic b3, input logic b5, input logic recover3);
        in3 = b3;
        in5 = b5;
        if (rst3) begin
            if (recover3) begin
                val3 = '0;
                exp3_q.push_back(1'b1);
            end else begin
                val3 = val3 * 2 + 128'(b3);
                exp3_q.push_back((val3 % 128'd3) == 128'd0);
            end
        end
        if (rst5) begin
            val5 = val5 * 2 + 128'(b5);
            exp5_q.push_back((val5 % 128'd5) == 128'd0);
        end
    endtask

    task automatic apply_stimulus(input logic b3, input logic b5);
        @(negedge clk);
        drive(b3, b5, 1'b0);
    endtask

    // Async reset pulse between edges for the selected DUTs; out must read 1 at once.
    task automatic restart(input logic do3, input logic do5);
        if (do3) begin rst3 = 1'b0; val3 = '0; end
        if (do5) begin rst5 = 1'b0; val5 = '0; end
        #1;
        if (do3) check_output("async_reset_out3", out3, 1'b1);
        if (do5) check_output("async_reset_out5", out5, 1'b1);
        if (do3) rst3 = 1'b1;
        if (do5) rst5 = 1'b1;
        #1;
        if (do3) check_output("release_out3", out3, 1'b1);
        if (do5) check_output("release_out5", out5, 1'b1);
    endtask

    // Monitor: pop one expectation per DUT after each edge that was given a bit.
    always @(posedge clk) begin
        #1;
        if (exp3_q.size() > 0) begin
            e3 = exp3_q.pop_front();
            check_output("mod3_out", out3, e3);
        end
        if (exp5_q.size() > 0) begin
            e5 = exp5_q.pop_front();
            check_output("mod5_out", out5, e5);
        end
    end

    logic [10:0] stream_a;
    logic        b;
    int          mode;

    initial begin
        checks   = 0;
        errors   = 0;
        rst3     = 1'b0;
        rst5     = 1'b0;
        in3      = 1'b0;
        in5      = 1'b0;
        val3     = '0;
        val5     = '0;
        stream_a = 11'b00111110110;

        // Held in reset with input toggling: residue stays zero.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in3 = ~in3;
            in5 = ~in5;
            #1;
            check_output("reset_out3", out3, 1'b1);
            check_output("reset_out5", out5, 1'b1);
            check_output("reset_r3_zero", logic'(dut3.r == 2'd0), 1'b1);
        end

        // Release and feed 0,0,1,1,1,1,1,0,1,1,0 (502).
        @(negedge clk);
        rst3 = 1'b1;
        #1;
        check_output("pre_edge_out3", out3, 1'b1);
        for (int i = 10; i >= 0; i--) begin
            if (i != 10) @(negedge clk);
            drive(stream_a[i], 1'b0, 1'b0);
        end

        // 1,1 -> 3, then 0 -> 6, then 1 -> 13.
        @(negedge clk);
        restart(1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0);

        // 1,0 leaves residue 2; reset mid-stream, then 1,1.
        @(negedge clk);
        restart(1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        @(negedge clk);
        restart(1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0);

        // Illegal residue 3 recovers to zero on the next edge, for in=1 and in=0.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            force dut3.r = 2'b11;
            #1;
            check_output("illegal_out3", out3, 1'b0);
            release dut3.r;
            #1;
            check_output("illegal_hold_out3", out3, 1'b0);
            drive(k == 0, 1'b0, 1'b1);
            apply_stimulus(1'b1, 1'b0);
            apply_stimulus(1'b1, 1'b0);
        end

        // Random 64-bit streams into both DUTs, including long constant runs.
        for (int s = 0; s < 16; s++) begin
            mode = s % 4;
            @(negedge clk);
            restart(1'b1, 1'b1);
            b = 1'b0;
            for (int k = 0; k < 64; k++) begin
                case (mode)
                    0:       b = 1'($urandom_range(0, 1));
                    1:       b = 1'b1;
                    2:       b = (k < 40) ? 1'b0 : 1'($urandom_range(0, 1));
                    default: b = ($urandom_range(0, 15) == 0) ? ~b : b;
                endcase
                if (k != 0) @(negedge clk);
                drive(1'($urandom_range(0, 1)), b, 1'b0);
            end
        end

        @(posedge clk);
        #3;
        if (exp3_q.size() != 0 || exp5_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL queue_drain: got %0d/%0d pending expected 0/0",
                     exp3_q.size(), exp5_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
